pre_mem_stage: RTL and testbench

Dual-issue pre-memory pipeline stage between the execute stage and the memory stage. Registers the paired instruction bundle from execute and issues up to two data-cache requests, one per port, via a valid/addr_ok handshake. It also generates byte strobes and lane-aligned store data, and forwards the bundle to the memory stage. Loads hand the memory stage a word-aligned access plus the 2-bit offset for result selection.

---
 rtl/pre_mem_stage_pkg.sv | 102 ++++++++++
 rtl/pre_mem_stage_store_align.sv | 43 ++++
 rtl/pre_mem_stage.sv | 134 +++++++++++++
 tb/tb_pre_mem_stage.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pre_mem_stage_pkg.sv
// Shared definitions for the pre-memory stage: bus layouts, widths, opcode bit order, excodes.
// Latency: none (types and pure functions only).
// Backpressure: n/a. Optional PMS_ADDR_EXC_EN adds per-instruction ex/excode to the memory-stage bus.
package pre_mem_stage_pkg;

    localparam int LD_LB  = 0;
    localparam int LD_LBU = 1;
    localparam int LD_LH  = 2;
    localparam int LD_LHU = 3;
    localparam int LD_LW  = 4;
    localparam int LD_LWL = 5;
    localparam int LD_LWR = 6;

    localparam int ST_SB  = 0;
    localparam int ST_SH  = 1;
    localparam int ST_SW  = 2;
    localparam int ST_SWL = 3;
    localparam int ST_SWR = 4;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef struct packed {
        logic [6:0]  load_type;
        logic [4:0]  store_type;
        logic        res_from_mem;
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] rt_value;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } inst_t;

    typedef struct packed {
        logic  inst2_valid;
        inst_t i2;
        inst_t i1;
    } es_bus_t;

    typedef struct packed {
        logic [6:0]  load_type;
        logic        res_from_mem;
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [1:0]  offset;
        logic [31:0] alu_result;
        logic [31:0] pc;
`ifdef PMS_ADDR_EXC_EN
        logic        ex;
        logic [4:0]  excode;
`endif
    } ms_inst_t;

    typedef struct packed {
        logic     inst2_valid;
        ms_inst_t i2;
        ms_inst_t i1;
    } pms_bus_t;

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
    } fwd_inst_t;

    typedef struct packed {
        logic      valid;
        fwd_inst_t i2;
        fwd_inst_t i1;
    } fwd_bus_t;

    localparam int ES_TO_PMS_BUS_WD   = $bits(es_bus_t);
    localparam int PMS_TO_MS_BUS_WD   = $bits(pms_bus_t);
    localparam int PMS_FORWARD_BUS_WD = $bits(fwd_bus_t);

    function automatic logic misaligned(inst_t i);
        return ((i.load_type[LD_LH] | i.load_type[LD_LHU] | i.store_type[ST_SH]) & i.alu_result[0]) |
               ((i.load_type[LD_LW] | i.store_type[ST_SW]) & (|i.alu_result[1:0]));
    endfunction

    // A faulting instruction keeps travelling but loses every side effect.
    function automatic ms_inst_t to_ms(inst_t i, logic ex);
        ms_inst_t m;
        m.load_type    = i.load_type;
        m.res_from_mem = i.res_from_mem & ~ex;
        m.mem_we       = i.mem_we & ~ex;
        m.gr_we        = i.gr_we & ~ex;
        m.dest         = i.dest;
        m.offset       = i.alu_result[1:0];
        m.alu_result   = i.alu_result;
        m.pc           = i.pc;
`ifdef PMS_ADDR_EXC_EN
        m.ex           = ex;
        m.excode       = i.mem_we ? EXC_ADES : EXC_ADEL;
`endif
        return m;
    endfunction

endpackage

// File: rtl/pre_mem_stage_store_align.sv
// Store lane alignment: store_type/offset/rt -> byte strobes and lane-aligned write data.
// Latency: combinational.
// Backpressure: none; non-store inputs yield wstrb = 0, wdata = 0.
module pms_store_align
    import pre_mem_stage_pkg::*;
(
    input  logic [4:0]  store_type,
    input  logic [1:0]  off,
    input  logic [31:0] rt,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0;
        if (store_type[ST_SB]) begin
            wstrb = 4'b0001 << off;
            wdata = {4{rt[7:0]}};
        end else if (store_type[ST_SH]) begin
            wstrb = off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rt[15:0]}};
        end else if (store_type[ST_SW]) begin
            wstrb = 4'b1111;
            wdata = rt;
        end else if (store_type[ST_SWL]) begin
            case (off)
                2'd0:    begin wstrb = 4'b0001; wdata = {24'b0, rt[31:24]}; end
                2'd1:    begin wstrb = 4'b0011; wdata = {16'b0, rt[31:16]}; end
                2'd2:    begin wstrb = 4'b0111; wdata = {8'b0,  rt[31:8]};  end
                default: begin wstrb = 4'b1111; wdata = rt;                 end
            endcase
        end else if (store_type[ST_SWR]) begin
            case (off)
                2'd0:    begin wstrb = 4'b1111; wdata = rt;                 end
                2'd1:    begin wstrb = 4'b1110; wdata = {rt[23:0], 8'b0};  end
                2'd2:    begin wstrb = 4'b1100; wdata = {rt[15:0], 16'b0}; end
                default: begin wstrb = 4'b1000; wdata = {rt[7:0],  24'b0}; end
            endcase
        end
    end

endmodule

// File: rtl/pre_mem_stage.sv
// Dual-issue pre-memory stage: registers the execute bundle, issues up to two dcache requests.
// Latency: 1 cycle best case (addr_ok in the request cycle); requests only while ms_allowin.
// Backpressure: holds the bundle until both requests are accepted and ms_allowin; PMS_ADDR_EXC_EN adds alignment faults.
module pre_mem_stage
    import pre_mem_stage_pkg::*;
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ms_allowin,
    output logic                          pms_allowin,
    input  logic                          es_to_pms_valid,
    input  logic [ES_TO_PMS_BUS_WD-1:0]   es_to_pms_bus,
    output logic                          pms_to_ms_valid,
    output logic [PMS_TO_MS_BUS_WD-1:0]   pms_to_ms_bus,
    output logic [PMS_FORWARD_BUS_WD-1:0] pms_forward_bus,
    output logic                          data_cache_valid_01,
    output logic                          data_cache_op_01,
    output logic [31:0]                   data_cache_addr_01,
    output logic [3:0]                    data_cache_wstrb_01,
    output logic [31:0]                   data_cache_wdata_01,
    input  logic                          data_cache_addr_ok_01,
    output logic                          data_cache_valid_02,
    output logic                          data_cache_op_02,
    output logic [31:0]                   data_cache_addr_02,
    output logic [3:0]                    data_cache_wstrb_02,
    output logic [31:0]                   data_cache_wdata_02,
    input  logic                          data_cache_addr_ok_02
);

    es_bus_t  bus_r;
    inst_t    i1, i2;
    logic     pms_valid, req_done_1, req_done_2;
    logic     ex_1, ex_2, inst2_valid;
    logic     mem_op_1, mem_op_2, inst_ready_1, inst_ready_2, pms_ready_go;
    ms_inst_t ms1, ms2;
    pms_bus_t ms_bus;
    fwd_bus_t fwd;

    assign i1 = bus_r.i1;
    assign i2 = bus_r.i2;

`ifdef PMS_ADDR_EXC_EN
    // A faulting inst1 squashes inst2 entirely.
    assign ex_1        = misaligned(i1);
    assign ex_2        = bus_r.inst2_valid & misaligned(i2);
    assign inst2_valid = bus_r.inst2_valid & ~ex_1;
`else
    assign ex_1        = 1'b0;
    assign ex_2        = 1'b0;
    assign inst2_valid = bus_r.inst2_valid;
`endif

    assign mem_op_1 = (i1.res_from_mem | i1.mem_we) & ~ex_1;
    assign mem_op_2 = inst2_valid & (i2.res_from_mem | i2.mem_we) & ~ex_2;

    assign data_cache_valid_01 = pms_valid & mem_op_1 & ~req_done_1 & ms_allowin;
    assign data_cache_valid_02 = pms_valid & mem_op_2 & ~req_done_2 & ms_allowin;
    assign data_cache_op_01    = i1.mem_we;
    assign data_cache_op_02    = i2.mem_we;
    assign data_cache_addr_01  = {i1.alu_result[31:2], 2'b00};
    assign data_cache_addr_02  = {i2.alu_result[31:2], 2'b00};

    pms_store_align u_align_01 (
        .store_type (i1.store_type),
        .off        (i1.alu_result[1:0]),
        .rt         (i1.rt_value),
        .wstrb      (data_cache_wstrb_01),
        .wdata      (data_cache_wdata_01)
    );

    pms_store_align u_align_02 (
        .store_type (i2.store_type),
        .off        (i2.alu_result[1:0]),
        .rt         (i2.rt_value),
        .wstrb      (data_cache_wstrb_02),
        .wdata      (data_cache_wdata_02)
    );

    assign inst_ready_1    = ~mem_op_1 | req_done_1 | data_cache_addr_ok_01;
    assign inst_ready_2    = ~mem_op_2 | req_done_2 | data_cache_addr_ok_02;
    assign pms_ready_go    = inst_ready_1 & inst_ready_2;
    assign pms_allowin     = ~pms_valid | (pms_ready_go & ms_allowin);
    assign pms_to_ms_valid = pms_valid & pms_ready_go;

    assign ms1 = to_ms(i1, ex_1);
    assign ms2 = to_ms(i2, ex_2);

    always_comb begin
        ms_bus.inst2_valid = inst2_valid;
        ms_bus.i1          = ms1;
        ms_bus.i2          = ms2;
    end
    assign pms_to_ms_bus = ms_bus;

    always_comb begin
        fwd.valid           = pms_valid;
        fwd.i1.res_from_mem = ms1.res_from_mem;
        fwd.i1.gr_we        = ms1.gr_we;
        fwd.i1.dest         = i1.dest;
        fwd.i1.alu_result   = i1.alu_result;
        fwd.i2.res_from_mem = ms2.res_from_mem;
        fwd.i2.gr_we        = ms2.gr_we & inst2_valid;
        fwd.i2.dest         = i2.dest;
        fwd.i2.alu_result   = i2.alu_result;
    end
    assign pms_forward_bus = fwd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pms_valid  <= 1'b0;
            req_done_1 <= 1'b0;
            req_done_2 <= 1'b0;
        end else begin
            if (pms_allowin) begin
                pms_valid <= es_to_pms_valid;
            end
            if (es_to_pms_valid && pms_allowin) begin
                req_done_1 <= 1'b0;
                req_done_2 <= 1'b0;
            end else begin
                if (data_cache_valid_01 && data_cache_addr_ok_01) req_done_1 <= 1'b1;
                if (data_cache_valid_02 && data_cache_addr_ok_02) req_done_2 <= 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only observed while pms_valid is set.
    always_ff @(posedge clk) begin
        if (es_to_pms_valid && pms_allowin) begin
            bus_r <= es_to_pms_bus;
        end
    end

endmodule

// File: tb/tb_pre_mem_stage.sv
module tb_pre_mem_stage;
    import pre_mem_stage_pkg::*;

    logic                          clk = 1'b0;
    logic                          resetn = 1'b1;
    logic                          ms_allowin = 1'b0;
    logic                          pms_allowin;
    logic                          es_to_pms_valid = 1'b0;
    logic [ES_TO_PMS_BUS_WD-1:0]   es_to_pms_bus = '0;
    logic                          pms_to_ms_valid;
    logic [PMS_TO_MS_BUS_WD-1:0]   pms_to_ms_bus;
    logic [PMS_FORWARD_BUS_WD-1:0] pms_forward_bus;
    logic                          data_cache_valid_01, data_cache_op_01, data_cache_addr_ok_01 = 1'b0;
    logic                          data_cache_valid_02, data_cache_op_02, data_cache_addr_ok_02 = 1'b0;
    logic [31:0]                   data_cache_addr_01, data_cache_wdata_01;
    logic [31:0]                   data_cache_addr_02, data_cache_wdata_02;
    logic [3:0]                    data_cache_wstrb_01, data_cache_wstrb_02;

    always #5 clk = ~clk;

    pre_mem_stage dut (
        .clk                   (clk),
        .resetn                (resetn),
        .ms_allowin            (ms_allowin),
        .pms_allowin           (pms_allowin),
        .es_to_pms_valid       (es_to_pms_valid),
        .es_to_pms_bus         (es_to_pms_bus),
        .pms_to_ms_valid       (pms_to_ms_valid),
        .pms_to_ms_bus         (pms_to_ms_bus),
        .pms_forward_bus       (pms_forward_bus),
        .data_cache_valid_01   (data_cache_valid_01),
        .data_cache_op_01      (data_cache_op_01),
        .data_cache_addr_01    (data_cache_addr_01),
        .data_cache_wstrb_01   (data_cache_wstrb_01),
        .data_cache_wdata_01   (data_cache_wdata_01),
        .data_cache_addr_ok_01 (data_cache_addr_ok_01),
        .data_cache_valid_02   (data_cache_valid_02),
        .data_cache_op_02      (data_cache_op_02),
        .data_cache_addr_02    (data_cache_addr_02),
        .data_cache_wstrb_02   (data_cache_wstrb_02),
        .data_cache_wdata_02   (data_cache_wdata_02),
        .data_cache_addr_ok_02 (data_cache_addr_ok_02)
    );

    pms_bus_t ob;
    fwd_bus_t fb;
    assign ob = pms_to_ms_bus;
    assign fb = pms_forward_bus;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the bundle the stage should hold and which of its requests were accepted.
    bit      m_valid = 1'b0;
    es_bus_t m_b     = '0;
    bit      m_d1 = 1'b0, m_d2 = 1'b0;
    int      acc1 = 0, acc2 = 0;
    bit      e_m1, e_m2, e_v1, e_v2, e_ok1, e_ok2, e_go, e_allow;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_mem(inst_t i);
        return i.res_from_mem || i.mem_we;
    endfunction

    // kind: 0 alu, 1..7 load (load_type bit kind-1), 8..12 store (store_type bit kind-8)
    function automatic inst_t mk_inst(int kind, logic [31:0] addr, logic [31:0] rt,
                                      logic [4:0] dest, logic [31:0] pc);
        inst_t i;
        i = '0;
        i.alu_result = addr;
        i.rt_value   = rt;
        i.dest       = dest;
        i.pc         = pc;
        if (kind >= 1 && kind <= 7) begin
            i.load_type[kind-1] = 1'b1;
            i.res_from_mem = 1'b1;
            i.gr_we = 1'b1;
        end else if (kind >= 8 && kind <= 12) begin
            i.store_type[kind-8] = 1'b1;
            i.mem_we = 1'b1;
        end else begin
            i.gr_we = 1'b1;
        end
        return i;
    endfunction

    function automatic es_bus_t mkb(inst_t a, inst_t c, bit v2);
        es_bus_t b;
        b.inst2_valid = v2;
        b.i1 = a;
        b.i2 = c;
        return b;
    endfunction

    function automatic inst_t rnd_inst();
        return mk_inst(int'($urandom_range(0, 12)), $urandom, $urandom,
                       5'($urandom_range(0, 31)), $urandom);
    endfunction

    // Lane view: which rt byte lands in each memory lane, returns {wstrb, wdata}.
    function automatic logic [35:0] exp_store(inst_t i);
        logic [3:0]  s;
        logic [31:0] d;
        logic [7:0]  b [4];
        int off;
        s = '0;
        d = '0;
        off = int'(i.alu_result[1:0]);
        for (int k = 0; k < 4; k++) b[k] = i.rt_value[8*k +: 8];
        for (int lane = 0; lane < 4; lane++) begin
            if (i.store_type[ST_SB]) begin
                d[8*lane +: 8] = b[0];
                s[lane] = (lane == off);
            end else if (i.store_type[ST_SH]) begin
                d[8*lane +: 8] = b[lane % 2];
                s[lane] = (lane / 2 == off / 2);
            end else if (i.store_type[ST_SW]) begin
                d[8*lane +: 8] = b[lane];
                s[lane] = 1'b1;
            end else if (i.store_type[ST_SWL]) begin
                if (lane <= off) begin
                    d[8*lane +: 8] = b[3 - off + lane];
                    s[lane] = 1'b1;
                end
            end else if (i.store_type[ST_SWR]) begin
                if (lane >= off) begin
                    d[8*lane +: 8] = b[lane - off];
                    s[lane] = 1'b1;
                end
            end
        end
        return {s, d};
    endfunction

    task automatic check_port(string p, inst_t i, logic op, logic [31:0] addr,
                              logic [3:0] strb, logic [31:0] dat);
        logic [35:0] sd;
        sd = exp_store(i);
        check({p, "_op"},    op,   i.mem_we);
        check({p, "_addr"},  addr, {i.alu_result[31:2], 2'b00});
        check({p, "_wstrb"}, strb, sd[35:32]);
        check({p, "_wdata"}, dat,  sd[31:0]);
    endtask

    // Call at posedge+1: apply inputs, answer as a contract-abiding cache, compare against model.
    task automatic drive(bit es_v, es_bus_t b, bit ms_al, bit rnd, bit ok1r, bit ok2r);
        bit k;
        es_to_pms_valid = es_v;
        es_to_pms_bus   = b;
        ms_allowin      = ms_al;
        e_m1 = is_mem(m_b.i1);
        e_m2 = m_b.inst2_valid && is_mem(m_b.i2);
        e_v1 = m_valid && e_m1 && !m_d1 && ms_al;
        e_v2 = m_valid && e_m2 && !m_d2 && ms_al;
        if (rnd) begin
            if (e_v1 && e_v2) begin
                k = 1'($urandom_range(0, 1));
                e_ok1 = k;
                e_ok2 = k;
            end else begin
                e_ok1 = e_v1 && ($urandom_range(0, 1) == 1);
                e_ok2 = e_v2 && ($urandom_range(0, 1) == 1);
            end
        end else begin
            e_ok1 = ok1r && e_v1;
            e_ok2 = ok2r && e_v2;
        end
        data_cache_addr_ok_01 = e_ok1;
        data_cache_addr_ok_02 = e_ok2;
        e_go    = (!e_m1 || m_d1 || e_ok1) && (!e_m2 || m_d2 || e_ok2);
        e_allow = !m_valid || (e_go && ms_al);
        #2;
        check("pms_allowin", pms_allowin, e_allow);
        check("pms_to_ms_valid", pms_to_ms_valid, m_valid && e_go);
        check("fwd_valid", fb.valid, m_valid);
        check("valid_01", data_cache_valid_01, e_v1);
        check("valid_02", data_cache_valid_02, e_v2);
        if (e_v1) check_port("p01", m_b.i1, data_cache_op_01, data_cache_addr_01,
                             data_cache_wstrb_01, data_cache_wdata_01);
        if (e_v2) check_port("p02", m_b.i2, data_cache_op_02, data_cache_addr_02,
                             data_cache_wstrb_02, data_cache_wdata_02);
        if (m_valid) begin
            check("ms_offset_1", ob.i1.offset, m_b.i1.alu_result[1:0]);
            check("ms_pc_1", ob.i1.pc, m_b.i1.pc);
            check("ms_inst2_valid", ob.inst2_valid, m_b.inst2_valid);
            check("ms_offset_2", ob.i2.offset, m_b.i2.alu_result[1:0]);
            check("fwd_dest_1", fb.i1.dest, m_b.i1.dest);
            check("fwd_res_1", fb.i1.res_from_mem, m_b.i1.res_from_mem);
            check("fwd_gr_we_2", fb.i2.gr_we, m_b.inst2_valid && m_b.i2.gr_we);
        end
    endtask

    // Advance the model across the coming edge, then wait for it.
    task automatic step();
        if (data_cache_valid_01 && data_cache_addr_ok_01) acc1++;
        if (data_cache_valid_02 && data_cache_addr_ok_02) acc2++;
        if (m_valid && e_go && ms_allowin) begin
            check("issue_once_1", acc1, e_m1);
            check("issue_once_2", acc2, e_m2);
            acc1 = 0;
            acc2 = 0;
        end
        if (e_allow && es_to_pms_valid) begin
            m_b  = es_to_pms_bus;
            m_d1 = 1'b0;
            m_d2 = 1'b0;
        end else begin
            if (e_v1 && e_ok1) m_d1 = 1'b1;
            if (e_v2 && e_ok2) m_d2 = 1'b1;
        end
        if (e_allow) m_valid = es_to_pms_valid;
        @(posedge clk);
        #1;
    endtask

    es_bus_t b;

    initial begin
        #1 resetn = 1'b0;
        #1;
        check("rst_valid_01", data_cache_valid_01, 1'b0);
        check("rst_valid_02", data_cache_valid_02, 1'b0);
        check("rst_to_ms_valid", pms_to_ms_valid, 1'b0);
        check("rst_fwd_valid", fb.valid, 1'b0);
        check("rst_allowin", pms_allowin, 1'b1);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // sw to a non-word-aligned address is issued word-aligned
        b = mkb(mk_inst(8 + ST_SW, 32'h1000_0006, 32'hAABB_CCDD, 5'd1, 32'h100), '0, 1'b0);
        drive(1, b, 1, 0, 0, 0); step();
        drive(0, '0, 1, 0, 1, 0);
        check("sw_valid_01", data_cache_valid_01, 1'b1);
        check("sw_addr_01", data_cache_addr_01, 32'h1000_0004);
        check("sw_wstrb_01", data_cache_wstrb_01, 4'b1111);
        check("sw_wdata_01", data_cache_wdata_01, 32'hAABB_CCDD);
        check("sw_valid_02", data_cache_valid_02, 1'b0);
        step();

        // sb + lw, both accepted in the first cycle
        b = mkb(mk_inst(8 + ST_SB, 32'h0000_0402, 32'h0000_0012, 5'd2, 32'h104),
                mk_inst(1 + LD_LW, 32'h2000_0000, 32'h0, 5'd3, 32'h108), 1'b1);
        drive(1, b, 1, 0, 0, 0); step();
        drive(0, '0, 1, 0, 1, 1);
        check("sb_wstrb_01", data_cache_wstrb_01, 4'b0100);
        check("sb_wdata_01", data_cache_wdata_01, 32'h1212_1212);
        check("lw_valid_02", data_cache_valid_02, 1'b1);
        check("lw_addr_02", data_cache_addr_02, 32'h2000_0000);
        check("lw_wstrb_02", data_cache_wstrb_02, 4'b0000);
        check("lw_wdata_02", data_cache_wdata_02, 32'h0);
        check("dual_to_ms", pms_to_ms_valid, 1'b1);
        step();
        drive(0, '0, 1, 0, 0, 0);
        check("no_reissue_01", data_cache_valid_01, 1'b0);
        check("no_reissue_02", data_cache_valid_02, 1'b0);
        step();

        // memory stage stalls for 3 cycles with a loaded lw
        b = mkb(mk_inst(1 + LD_LW, 32'h4000_0010, 32'h0, 5'd4, 32'h10C), '0, 1'b0);
        drive(1, b, 0, 0, 0, 0); step();
        for (int n = 0; n < 3; n++) begin
            drive(0, '0, 0, 0, 1, 0);
            check("stall_valid_01", data_cache_valid_01, 1'b0);
            step();
        end
        drive(0, '0, 1, 0, 1, 0);
        check("unstall_valid_01", data_cache_valid_01, 1'b1);
        check("unstall_to_ms", pms_to_ms_valid, 1'b1);
        step();

        // swr/swl pair, addr_ok withheld twice, new bundle enters on release
        b = mkb(mk_inst(8 + ST_SWR, 32'h5000_0001, 32'h1122_3344, 5'd5, 32'h110),
                mk_inst(8 + ST_SWL, 32'h5000_0005, 32'h1122_3344, 5'd6, 32'h114), 1'b1);
        drive(1, b, 1, 0, 0, 0); step();
        for (int n = 0; n < 2; n++) begin
            drive(0, '0, 1, 0, 0, 0);
            check("hold_allowin", pms_allowin, 1'b0);
            check("swr_wstrb_01", data_cache_wstrb_01, 4'b1110);
            check("swr_wdata_01", data_cache_wdata_01, 32'h2233_4400);
            check("swl_wstrb_02", data_cache_wstrb_02, 4'b0011);
            check("swl_wdata_02", data_cache_wdata_02, 32'h0000_1122);
            step();
        end
        b = mkb(mk_inst(1 + LD_LW, 32'h3000_0008, 32'h0, 5'd7, 32'h118), '0, 1'b0);
        drive(1, b, 1, 0, 1, 1);
        check("release_to_ms", pms_to_ms_valid, 1'b1);
        check("release_allowin", pms_allowin, 1'b1);
        step();
        drive(0, '0, 1, 0, 0, 0);
        check("next_valid_01", data_cache_valid_01, 1'b1);
        check("next_addr_01", data_cache_addr_01, 32'h3000_0008);
        step();
        drive(0, '0, 1, 0, 1, 0); step();

        // asynchronous reset while a dual request is pending
        b = mkb(mk_inst(1 + LD_LW, 32'h6000_0000, 32'h0, 5'd8, 32'h11C),
                mk_inst(1 + LD_LB, 32'h6000_0011, 32'h0, 5'd9, 32'h120), 1'b1);
        drive(1, b, 1, 0, 0, 0); step();
        drive(0, '0, 1, 0, 0, 0);
        #1 resetn = 1'b0;
        #1;
        check("mid_rst_valid_01", data_cache_valid_01, 1'b0);
        check("mid_rst_valid_02", data_cache_valid_02, 1'b0);
        check("mid_rst_to_ms", pms_to_ms_valid, 1'b0);
        check("mid_rst_fwd_valid", fb.valid, 1'b0);
        m_valid = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0; acc1 = 0; acc2 = 0;
        @(posedge clk);
        #1 resetn = 1'b1;

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            b = mkb(rnd_inst(), rnd_inst(), 1'($urandom_range(0, 1)));
            drive(($urandom_range(0, 99) < 60), b, ($urandom_range(0, 99) < 70), 1, 0, 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
